// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive framer.
//   rx_state_e    : framer state encoding (3 bits). PARITY keeps its code even
//                   in builds without parity so encodings never shift.
//   DATA_BITS_MAX : widest supported data field.
//   LINE_IDLE     : level of the serial line when nothing is being sent.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS_MAX = 8;
    localparam logic LINE_IDLE     = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and flags the
// idle-to-start falling edge.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rs232_rx   : raw serial line (idle high)
//   rx_s       : synchronized line level
//   fall       : one-cycle strobe, previous sample 1 and current sample 0
// All flops reset to the idle level so no phantom edge appears after reset.
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rs232_rx};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE}};
            prev_q <= LINE_IDLE;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
// UART receive framer driven by an external baud tick generator.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rs232_rx   : serial line, idle high
//   bps_clk    : one-cycle mid-bit tick from the baud generator
//   bps_en     : enables the baud generator for the whole frame
//   rx_data    : last good byte, held until the next good frame
//   rx_valid   : one-cycle pulse when rx_data is updated
//   frame_err  : one-cycle pulse on false start, bad stop bit or bad parity
//   rx_busy    : high whenever the framer is not idle
// Build option: define RX_PARITY_EN to add a parity bit after the data bits
// (PARITY_ODD selects odd parity). Without it a frame is start+data+stop.
// ----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 bps_clk,
    output logic                 bps_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    // Reject configurations outside the supported ranges at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_frame: DATA_BITS out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("uart_rx_frame: SYNC_STAGES out of range");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
    end

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs232_rx(rs232_rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    rx_state_e             state_q, state_d;
    logic                  bps_en_q, bps_en_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  parity_err;

`ifdef RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Next-state and output logic; every sampling decision waits for bps_clk
    // except the falling-edge wakeup in IDLE.
    always_comb begin
        state_d     = state_q;
        bps_en_d    = bps_en_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d  = START;
                    bps_en_d = 1'b1;
                end
            end
            START: begin
                if (bps_clk) begin
                    if (rx_s == 1'b0) begin
                        bit_cnt_d = '0;
`ifdef RX_PARITY_EN
                        parity_err_d = 1'b0;
`endif
                        state_d   = DATA;
                    end else begin
                        // Line bounced back high before mid-start: false start.
                        frame_err_d = 1'b1;
                        bps_en_d    = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            DATA: begin
                if (bps_clk) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef RX_PARITY_EN
                if (bps_clk) begin
                    parity_err_d = ((^shift_q) ^ rx_s) != 1'(PARITY_ODD);
                    state_d      = STOP;
                end
`else
                // Unreachable without parity; recover to idle if ever entered.
                state_d  = IDLE;
                bps_en_d = 1'b0;
`endif
            end
            STOP: begin
                if (bps_clk) begin
                    bps_en_d = 1'b0;
                    state_d  = IDLE;
                    if (rx_s && !parity_err) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                bps_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bps_en_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bps_en_q    <= bps_en_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
`ifdef RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bps_en    = bps_en_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
